// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between instruction fetch (if_*) and load/store (dm_*).
// Latency : gnt combinational in IDLE, mem_req from the next cycle, rvalid one cycle after mem_ack (min 2).
// Backpress: one transaction outstanding; requests are held by the requester until gnt, mem_req held until mem_ack.
//
// Ports
//   clk_i, reset_i                 clock (rising edge), asynchronous active-high reset
//   if_req_i/if_addr_i             fetch request; if_gnt_o accept; if_rvalid_o/if_rdata_o/if_err_o response
//   dm_req_i/dm_we_i/dm_be_i/
//   dm_addr_i/dm_wdata_i           load/store request; dm_gnt_o accept; dm_rvalid_o/dm_rdata_o/dm_err_o response
//   mem_req_o/mem_we_o/mem_be_o/
//   mem_addr_o/mem_wdata_o         memory request, held until mem_ack_i; mem_rdata_i valid with mem_ack_i
//
// Build option: define MEM_ARB_FAIR_EN to limit consecutive dm grants to MAX_DM_BURST while a fetch waits.
// Without it dm has strict priority and fetch may starve.

module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned MAX_DM_BURST = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [AW-1:0]     if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DW-1:0]     if_rdata_o,
    output logic              if_err_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [DW/8-1:0]   dm_be_i,
    input  logic [AW-1:0]     dm_addr_i,
    input  logic [DW-1:0]     dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DW-1:0]     dm_rdata_o,
    output logic              dm_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DW/8-1:0]   mem_be_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DW-1:0]     mem_rdata_i
);

    localparam int unsigned BW = DW / 8;
    // Counter sized for the timeout alone; a 1-bit stub when the timeout is disabled.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [BW-1:0] be_q, be_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;

    logic is_idle;
    logic force_if;
    logic dm_win;
    logic if_win;
    logic grant;
    logic timeout_hit;

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned SW = (MAX_DM_BURST > 0) ? $clog2(MAX_DM_BURST + 1) : 1;
    logic [SW-1:0] streak_q, streak_d;

    // Once dm has won MAX_DM_BURST times in a row over a waiting fetch, fetch takes the next slot.
    assign force_if = if_req_i && (streak_q >= SW'(MAX_DM_BURST));

    always_comb begin
        streak_d = streak_q;
        if (grant) begin
            if (!dm_win || !if_req_i) begin
                streak_d = '0;
            end else begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign is_idle = (state_q == S_IDLE);
    assign dm_win  = dm_req_i && !force_if;
    assign if_win  = if_req_i && !dm_win;
    assign grant   = is_idle && (dm_win || if_win);

    assign dm_gnt_o = is_idle && dm_win;
    assign if_gnt_o = is_idle && if_win;

    // Ack on the last allowed cycle still counts as success, hence the !mem_ack_i term.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !mem_ack_i;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // mem_ack_i seen here is late or spurious and is deliberately ignored.
                if (grant) begin
                    state_d = S_WAIT;
                    owner_d = dm_win ? OWN_DM : OWN_IF;
                    addr_d  = dm_win ? dm_addr_i : if_addr_i;
                    we_d    = dm_win && dm_we_i;
                    be_d    = dm_win ? dm_be_i : '1;
                    wdata_d = dm_win ? dm_wdata_i : '0;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem_ack_i) begin
                    state_d  = S_IDLE;
                    rdata_d  = we_q ? '0 : mem_rdata_i;
                    rvalid_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d  = S_IDLE;
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign mem_req_o   = (state_q == S_WAIT);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // Responses are steered to the owner only; the other side stays quiet.
    assign if_rvalid_o = rvalid_q && (owner_q == OWN_IF);
    assign if_err_o    = err_q    && (owner_q == OWN_IF);
    assign if_rdata_o  = (owner_q == OWN_IF) ? rdata_q : '0;
    assign dm_rvalid_o = rvalid_q && (owner_q == OWN_DM);
    assign dm_err_o    = err_q    && (owner_q == OWN_DM);
    assign dm_rdata_o  = (owner_q == OWN_DM) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed bench for mem_port_arbiter with a response scoreboard.
// Latency : responses are expected exactly one cycle after mem_ack / timeout.
// Backpress: requests are held until gnt, as a real requester would.

module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        dm_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(8), .MAX_DM_BURST(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_dm, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_dm = is_dm;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Called once per cycle, #1 after the rising edge, to score any response.
    task automatic service_rsp();
        logic [1:0] rv;
        exp_t       e;
        rv = {if_rvalid_o, dm_rvalid_o};
        if (rv != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rvalid", 64'(rv), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rv_owner", 64'(rv), e.is_dm ? 64'd1 : 64'd2);
                chk("rdata", e.is_dm ? 64'(dm_rdata_o) : 64'(if_rdata_o), 64'(e.rdata));
                chk("err", e.is_dm ? 64'(dm_err_o) : 64'(if_err_o), 64'(e.err));
                chk("other_err", e.is_dm ? 64'(if_err_o) : 64'(dm_err_o), 64'd0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        service_rsp();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"}, 64'({if_gnt_o, dm_gnt_o}), 64'd0);
        chk({tag, "_rvalid"}, 64'({if_rvalid_o, dm_rvalid_o}), 64'd0);
        chk({tag, "_errs"}, 64'({if_err_o, dm_err_o}), 64'd0);
        chk({tag, "_rdata"}, {if_rdata_o, dm_rdata_o}, 64'd0);
        chk({tag, "_mem_ctl"}, 64'({mem_req_o, mem_we_o, mem_be_o}), 64'd0);
        chk({tag, "_mem_dat"}, {mem_addr_o, mem_wdata_o}, 64'd0);
    endtask

    initial begin
        int mreq_cnt;
        bit fair;
        bit want_if;
`ifdef MEM_ARB_FAIR_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        reset_i = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_idle_outputs("reset");
        reset_i = 1'b0;
        step();

        // 1: single fetch, ack three cycles after mem_req rises.
        if_req_i = 1'b1; if_addr_i = 32'h40;
        #1;
        chk("t1_if_gnt", 64'({if_gnt_o, dm_gnt_o}), 64'd2);
        push(1'b0, 32'h00500093, 1'b0);
        step();
        if_req_i = 1'b0;
        chk("t1_mem_req", 64'({mem_req_o, mem_we_o}), 64'd2);
        chk("t1_mem_addr", 64'(mem_addr_o), 64'h40);
        repeat (3) step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00500093;
        step();
        mem_ack_i = 1'b0;
        chk("t1_rsp_done", 64'(exp_q.size()), 64'd0);
        chk("t1_mem_req_drop", 64'(mem_req_o), 64'd0);

        // 2: simultaneous requests, dm wins, fetch granted in the dm_rvalid cycle.
        if_req_i = 1'b1; if_addr_i = 32'h200;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h100;
        #1;
        chk("t2_dm_first", 64'({if_gnt_o, dm_gnt_o}), 64'd1);
        push(1'b1, 32'h11111111, 1'b0);
        step();
        dm_req_i = 1'b0;
        #1;
        chk("t2_no_gnt_in_wait", 64'({if_gnt_o, dm_gnt_o}), 64'd0);
        chk("t2_mem_addr_dm", 64'(mem_addr_o), 64'h100);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
        step();
        mem_ack_i = 1'b0;
        chk("t2_b2b", 64'({dm_rvalid_o, if_gnt_o}), 64'd3);
        push(1'b0, 32'h22222222, 1'b0);
        step();
        if_req_i = 1'b0;
        chk("t2_mem_addr_if", 64'(mem_addr_o), 64'h200);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222;
        step();
        mem_ack_i = 1'b0;
        chk("t2_rsp_done", 64'(exp_q.size()), 64'd0);

        // 3: dm write; request fields must stay latched while the requester changes inputs.
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011;
        dm_addr_i = 32'h300; dm_wdata_i = 32'hDEADBEEF;
        #1;
        chk("t3_dm_gnt", 64'(dm_gnt_o), 64'd1);
        push(1'b1, 32'h0, 1'b0);
        step();
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_wdata_i = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            chk("t3_mem_ctl", 64'({mem_req_o, mem_we_o, mem_be_o}), 64'h33);
            chk("t3_mem_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
            step();
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        step();
        mem_ack_i = 1'b0;
        chk("t3_rsp_done", 64'(exp_q.size()), 64'd0);

        // 4: timeout with no ack, then a late ack that must be ignored.
        if_req_i = 1'b1; if_addr_i = 32'h400;
        #1;
        chk("t4_if_gnt", 64'(if_gnt_o), 64'd1);
        push(1'b0, 32'h0, 1'b1);
        step();
        if_req_i = 1'b0;
        mreq_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_o) mreq_cnt++;
            step();
        end
        chk("t4_mem_req_cycles", 64'(mreq_cnt), 64'd8);
        chk("t4_rsp_done", 64'(exp_q.size()), 64'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        step();
        mem_ack_i = 1'b0;
        chk("t4_late_ack", 64'({if_rvalid_o, dm_rvalid_o}), 64'd0);
        step();

        // 4b: ack on the final allowed cycle counts as success.
        if_req_i = 1'b1; if_addr_i = 32'h600;
        #1;
        chk("t4b_if_gnt", 64'(if_gnt_o), 64'd1);
        push(1'b0, 32'hA5A5A5A5, 1'b0);
        step();
        if_req_i = 1'b0;
        repeat (7) step();
        chk("t4b_still_req", 64'(mem_req_o), 64'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
        step();
        mem_ack_i = 1'b0;
        chk("t4b_rsp_done", 64'(exp_q.size()), 64'd0);

        // 5: reset in the middle of a transaction drops it silently.
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h500;
        #1;
        chk("t5_dm_gnt", 64'(dm_gnt_o), 64'd1);
        step();
        dm_req_i = 1'b0;
        step();
        chk("t5_in_wait", 64'(mem_req_o), 64'd1);
        reset_i = 1'b1;
        #1;
        chk_idle_outputs("t5_reset");
        step();
        reset_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
        step();
        mem_ack_i = 1'b0;
        chk("t5_no_rsp", 64'({if_rvalid_o, dm_rvalid_o, mem_req_o}), 64'd0);
        repeat (2) step();

        // 6: both requesters held high; dm-only, or dm x4 then if with fairness.
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h700;
        if_req_i = 1'b1; if_addr_i = 32'h800;
        for (int k = 0; k < 10; k++) begin
            #1;
            want_if = fair && ((k % 5) == 4);
            chk($sformatf("t6_grant%0d", k), 64'({if_gnt_o, dm_gnt_o}), want_if ? 64'd2 : 64'd1);
            push(!want_if, 32'h1000 + 32'(k), 1'b0);
            step();
            if (k == 9) begin
                dm_req_i = 1'b0;
                if_req_i = 1'b0;
            end
            mem_ack_i = 1'b1; mem_rdata_i = 32'h1000 + 32'(k);
            step();
            mem_ack_i = 1'b0;
        end
        repeat (2) step();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
